cnnip_mem_responder: RTL
========================

# cnnip_mem_responder

Slave end of `cnnip_mem_if`, the memory that `cnnip_ctrlr` drives through its `to_input_mem`, `to_weight_mem` and `to_feature_mem` master ports. Three instances sit in the CNN IP, one per buffer region:
- input at 0x1000;
- weight at 0x2000;
- feature at 0x3000.

Each instance holds a word array with byte write enables and answers CNN reads with fixed 1-cycle latency. It also exposes a simple host request/ack port so software can preload inputs and weights and drain features. The CNN port has absolute priority; the host port stalls.

## Interface
Parameters:
- `BASE_ADDR`, default 16'h1000: byte address of word 0.
- `DEPTH`, default 1024: number of 32-bit words.
- `IDX_W`, default 10: `$clog2(DEPTH)`.

Ports:
- `clk_a` input 1: clock.
- `arstz_aq` input 1: reset, asynchronous, active-low.
- `from_cnnip` `cnnip_mem_if.slave`: `en`, `we[3:0]`, `addr[15:0]`, `din[31:0]` in; `dout[31:0]` out.
- `host_req` input 1: host access request; held until `host_ack`.
- `host_we` input 4: byte enables; 0 means read.
- `host_addr` input 16: byte address.
- `host_wdata` input 32: write data.
- `host_ack` output 1: one-cycle completion pulse.
- `host_rdata` output 32: read data, valid with `host_ack`.
- `host_err` output 1: out-of-range flag, valid with `host_ack`.
- `oob_clr` input 1: synchronous clear of `oob_count`.
- `oob_count` output 16: saturating count of out-of-range CNN accesses.

## Operation
- **Decode, both ports.** An address is in range iff all of the following hold:
  - `addr >= BASE_ADDR`;
  - `addr[1:0] == 0`;
  - `(addr - BASE_ADDR) >> 2 < DEPTH`.
  
  The word index is `(addr - BASE_ADDR) >> 2`, truncated to `IDX_W` bits.
- **CNN write** (`en=1`, `we!=0`, in range): write byte lanes `i` where `we[i]=1`; other lanes unchanged. `dout` holds its previous value.
- **CNN read** (`en=1`, `we=0`, in range): `dout` is the registered array word.
- **CNN out of range:**
  - read: `dout` is 0;
  - write: dropped;
  - either way, `oob_count` increments, saturating at 16'hFFFF.
- **`oob_clr`:** clears `oob_count`. If `oob_clr` and an out-of-range access occur in the same cycle, the result is 0 (clear wins).
- **Host FSM states:** `H_IDLE` and `H_RESP`.
  - `H_IDLE` to `H_RESP` when `host_req=1` and `from_cnnip.en=0`. The access executes in that cycle, using the same write and read rules as the CNN port.
  - While `from_cnnip.en=1`, the FSM stays in `H_IDLE`. No access, no ack. The stall is unbounded by design, because the CNN master cannot stall.
  - `H_RESP` always returns to `H_IDLE` after one cycle.
- **Host out of range:** acknowledge with `host_err=1` and `host_rdata=0`; no array write.
- **Host abort:** if `host_req` drops before acceptance, nothing happens.

## Timing
- **Reset values:** `dout`=0, `host_ack`=0, `host_rdata`=0, `host_err`=0, `oob_count`=0, FSM in `H_IDLE`. Array contents are not reset (undefined).
- **Reset mid-operation:** a pending or accepted host request is discarded and no ack is issued. An array write already clocked in that cycle stands.
- **CNN read latency:** address at edge N gives `dout` at N+1. `dout` holds until the next CNN read.
- **CNN write then read:** write at N, read of the same word at N+1 returns the new data at N+2.
- **Host latency:** request accepted in cycle N gives `host_ack`, `host_rdata` and `host_err` in N+1, for exactly 1 cycle.
  - `host_req` is ignored during `H_RESP`. The earliest next acceptance is N+2.
  - A host that keeps `host_req` high through the ack cycle issues a new request.
- **Simultaneous host and CNN access:** CNN executes and host waits, even if the addresses differ. No write collision is therefore possible.
- **Read data:** host reads never disturb `dout`; CNN reads never disturb `host_rdata`.

## Structure
- **Package `cnnip_pkg`:**
  - `CNNIP_INPUT_BASE`=16'h1000, `CNNIP_WEIGHT_BASE`=16'h2000, `CNNIP_FEATURE_BASE`=16'h3000;
  - `CNNIP_INPUT_DEPTH`=1024, `CNNIP_WEIGHT_DEPTH`=32, `CNNIP_FEATURE_DEPTH`=784;
  - `host_state_t` enum {`H_IDLE`, `H_RESP`}.
- **Sub-module `cnnip_bram_1rw`:**
  - single-port 32-bit array, `DEPTH` words;
  - 4-lane byte enable;
  - registered read;
  - no reset on the array.
  
  The responder muxes the CNN and host requests onto its single port.

## Test plan
- **CNN basic read/write.** Host writes 32'hCAFE_0001 to 0x1004 and is acked next cycle with `err=0`. CNN reads 0x1004 and gets `dout`=32'hCAFE_0001 one cycle later.
- **Byte enables.** CNN writes 32'h1122_3344 with `we`=4'b1111, then 32'hAABB_CCDD with `we`=4'b0101. A read returns 32'h11BB_33DD.
- **Arbitration.** Host read is requested while CNN `en` is high for 5 cycles. `host_ack` arrives exactly 1 cycle after `en` drops, and `dout` is unaffected.
- **Out of range.** CNN reads 0x0FFC, 0x2000 (DEPTH=1024) and 0x1002. `dout` is 0 each time and `oob_count`=3. Host write to 0x2000 gives `host_err`=1 and memory is unchanged. `oob_clr` plus a simultaneous out-of-range access gives `oob_count`=0.
- **Saturation.** Drive 65 540 out-of-range CNN reads; `oob_count` stays at 16'hFFFF.
- **Reset mid-op.** Assert `arstz_aq` in the acceptance cycle of a host read. No `host_ack` is issued and all outputs are 0. After release, a re-issued request completes normally.

Source files
------------

// File: rtl/cnnip_pkg.sv
// Shared constants and types for the CNN IP buffer memories.
// The in-range decode lives here so every buffer instance checks addresses the same way.
package cnnip_pkg;

    localparam logic [15:0] CNNIP_INPUT_BASE   = 16'h1000;
    localparam logic [15:0] CNNIP_WEIGHT_BASE  = 16'h2000;
    localparam logic [15:0] CNNIP_FEATURE_BASE = 16'h3000;

    localparam int unsigned CNNIP_INPUT_DEPTH   = 1024;
    localparam int unsigned CNNIP_WEIGHT_DEPTH  = 32;
    localparam int unsigned CNNIP_FEATURE_DEPTH = 784;

    typedef enum logic {
        H_IDLE = 1'b0,
        H_RESP = 1'b1
    } host_state_t;

    // Valid iff at/above base, word aligned and the word offset falls inside the array.
    function automatic logic addr_in_range(input logic [15:0] addr,
                                           input logic [15:0] base,
                                           input int unsigned depth);
        logic [31:0] word_off;
        word_off = 32'(addr - base) >> 2;
        return (addr >= base) && (addr[1:0] == 2'b00) && (word_off < depth);
    endfunction

endpackage

// File: rtl/cnnip_mem_if.sv
// Memory port driven by cnnip_ctrlr; dout returns registered read data one cycle later.
interface cnnip_mem_if;

    logic        en;
    logic [3:0]  we;
    logic [15:0] addr;
    logic [31:0] din;
    logic [31:0] dout;

    modport master (output en, we, addr, din, input dout);
    modport slave  (input en, we, addr, din, output dout);

endinterface

// File: rtl/cnnip_bram_1rw.sv
// Single-port word array with byte write enables and a registered read port.
// Contents and read register are deliberately not reset.
module cnnip_bram_1rw #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned IDX_W = 10
) (
    input  logic             clk_a,
    input  logic             en,
    input  logic [3:0]       we,
    input  logic [IDX_W-1:0] idx,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] mem [DEPTH];
    logic [31:0] rdata_q;

    always_ff @(posedge clk_a) begin
        if (en) begin
            if (we != 4'b0000) begin
                for (int i = 0; i < 4; i++) begin
                    if (we[i]) begin
                        mem[idx][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end else begin
                rdata_q <= mem[idx];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/cnnip_mem_responder.sv
// Buffer memory answering cnnip_ctrlr with 1-cycle reads, plus a host req/ack port
// that only gets the array when the CNN port is idle.
module cnnip_mem_responder
    import cnnip_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'h1000,
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned IDX_W     = 10
) (
    input  logic        clk_a,
    input  logic        arstz_aq,
    cnnip_mem_if.slave  from_cnnip,
    input  logic        host_req,
    input  logic [3:0]  host_we,
    input  logic [15:0] host_addr,
    input  logic [31:0] host_wdata,
    output logic        host_ack,
    output logic [31:0] host_rdata,
    output logic        host_err,
    input  logic        oob_clr,
    output logic [15:0] oob_count
);

    logic             cnn_in_range, host_in_range;
    logic [IDX_W-1:0] cnn_idx, host_idx;
    logic             cnn_go, cnn_rd_hit, cnn_oob, cnn_oob_rd;
    logic             host_accept, host_go, host_rd_hit;

    logic             bram_en;
    logic [3:0]       bram_we;
    logic [IDX_W-1:0] bram_idx;
    logic [31:0]      bram_wdata, bram_rdata;

    host_state_t      state_q, state_d;
    logic             cnn_rd_hit_q, host_rd_hit_q, host_err_q, host_err_d;
    logic [31:0]      dout_q, dout_d, host_rdata_q, host_rdata_d;
    logic [15:0]      oob_count_q, oob_count_d;

    assign cnn_in_range  = addr_in_range(from_cnnip.addr, BASE_ADDR, DEPTH);
    assign host_in_range = addr_in_range(host_addr, BASE_ADDR, DEPTH);
    assign cnn_idx       = IDX_W'((from_cnnip.addr - BASE_ADDR) >> 2);
    assign host_idx      = IDX_W'((host_addr - BASE_ADDR) >> 2);

    assign cnn_go      = from_cnnip.en && cnn_in_range;
    assign cnn_rd_hit  = cnn_go && (from_cnnip.we == 4'b0000);
    assign cnn_oob     = from_cnnip.en && !cnn_in_range;
    assign cnn_oob_rd  = cnn_oob && (from_cnnip.we == 4'b0000);

    // Host is accepted only while idle and the CNN port is quiet; CNN never waits.
    assign host_accept = (state_q == H_IDLE) && host_req && !from_cnnip.en;
    assign host_go     = host_accept && host_in_range;
    assign host_rd_hit = host_go && (host_we == 4'b0000);

    always_comb begin
        bram_en    = cnn_go || host_go;
        bram_we    = host_we;
        bram_idx   = host_idx;
        bram_wdata = host_wdata;
        if (from_cnnip.en) begin
            bram_we    = from_cnnip.we;
            bram_idx   = cnn_idx;
            bram_wdata = from_cnnip.din;
        end
    end

    cnnip_bram_1rw #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_bram (
        .clk_a (clk_a),
        .en    (bram_en),
        .we    (bram_we),
        .idx   (bram_idx),
        .wdata (bram_wdata),
        .rdata (bram_rdata)
    );

    always_comb begin
        state_d = host_accept ? H_RESP : H_IDLE;
    end

    // The shared read register is only meaningful right after its own reader's access,
    // so each port latches it then and holds its own copy afterwards.
    always_comb begin
        dout_d = dout_q;
        if (cnn_rd_hit_q) begin
            dout_d = bram_rdata;
        end
        if (cnn_oob_rd) begin
            dout_d = 32'h0;
        end
    end

    always_comb begin
        host_rdata_d = host_rdata_q;
        host_err_d   = host_err_q;
        if (host_rd_hit_q) begin
            host_rdata_d = bram_rdata;
        end
        if (host_accept) begin
            host_err_d = !host_in_range;
            if (!host_in_range) begin
                host_rdata_d = 32'h0;
            end
        end
    end

    always_comb begin
        oob_count_d = oob_count_q;
        if (oob_clr) begin
            oob_count_d = 16'h0;
        end else if (cnn_oob && (oob_count_q != 16'hFFFF)) begin
            oob_count_d = oob_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk_a or negedge arstz_aq) begin
        if (!arstz_aq) begin
            state_q       <= H_IDLE;
            cnn_rd_hit_q  <= 1'b0;
            host_rd_hit_q <= 1'b0;
            host_err_q    <= 1'b0;
            dout_q        <= 32'h0;
            host_rdata_q  <= 32'h0;
            oob_count_q   <= 16'h0;
        end else begin
            state_q       <= state_d;
            cnn_rd_hit_q  <= cnn_rd_hit;
            host_rd_hit_q <= host_rd_hit;
            host_err_q    <= host_err_d;
            dout_q        <= dout_d;
            host_rdata_q  <= host_rdata_d;
            oob_count_q   <= oob_count_d;
        end
    end

    assign from_cnnip.dout = cnn_rd_hit_q ? bram_rdata : dout_q;
    assign host_ack        = (state_q == H_RESP);
    assign host_err        = host_ack && host_err_q;
    assign host_rdata      = host_rd_hit_q ? bram_rdata : host_rdata_q;
    assign oob_count       = oob_count_q;

endmodule
